// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: widths, funct encodings,
// the ID/EX payload and immediate sign extension.
package alu_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned IMMW = 16;
    localparam int unsigned FW   = 3;
    localparam int unsigned CNTW = 32;

    // ALU op encodings; 3'b111 is undefined and treated as CERO by the ALU.
    typedef enum logic [FW-1:0] {
        FN_CERO = 3'b000,
        FN_ADD  = 3'b001,
        FN_SUB  = 3'b010,
        FN_AND  = 3'b011,
        FN_OR   = 3'b100,
        FN_NOT  = 3'b101,
        FN_XOR  = 3'b110
    } funct_e;

    // ID/EX pipeline register contents. funct stays raw so 3'b111 passes through.
    typedef struct packed {
        logic            valid;
        logic [FW-1:0]   funct;
        logic [AW-1:0]   rd;
        logic [DW-1:0]   data1;
        logic [DW-1:0]   data2;
    } idex_t;

    function automatic logic [DW-1:0] sign_extend(input logic [IMMW-1:0] imm);
        return {{(DW-IMMW){imm[IMMW-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// reg_file_2r1w: 32-entry register file, two operand read ports plus a debug
// read port (all combinational), one synchronous write port, r0 reads zero.
// Ports:
//   clk, rst                 clock, async active-high reset (clears all entries)
//   i_we, i_waddr, i_wdata   write port; writes to r0 are ignored
//   i_raddr1 / o_rdata1      operand read port 1
//   i_raddr2 / o_rdata2      operand read port 2
//   i_dbg_addr / o_dbg_data  debug read port
module reg_file_2r1w
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr1,
    output logic [DW-1:0] o_rdata1,
    input  logic [AW-1:0] i_raddr2,
    output logic [DW-1:0] o_rdata2,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [DW-1:0] o_dbg_data
);

    logic [DW-1:0] r_mem [NREG];

    // Storage with async clear; r0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Reads bypass storage for r0 so it is hardwired to zero.
    always_comb begin
        o_rdata1   = (i_raddr1   == '0) ? '0 : r_mem[i_raddr1];
        o_rdata2   = (i_raddr2   == '0) ? '0 : r_mem[i_raddr2];
        o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand/issue stage ahead of the ALU. Accepts one decoded instruction per
// cycle, reads operands (with forwarding of the ALU result in EX), loads the
// ID/EX register, writes the ALU result back and counts retired instructions.
// Ports:
//   clk, rst                         clock, async active-high reset
//   in_valid/in_ready                instruction handshake (in_ready = ~hold)
//   in_funct, in_rs1, in_rs2, in_rd  decoded instruction fields
//   in_use_imm, in_imm               immediate select and value
//   hold                             downstream stall, inserts a bubble
//   funct, data1, data2              ID/EX register driving the ALU
//   alu_out, zero                    combinational ALU result and zero flag
//   ex_valid, ex_rd                  EX instruction valid and destination
//   zero_flag, retired               last retired zero flag, retire counter
//   dbg_addr, dbg_data               debug register file read
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FW-1:0]   in_funct,
    input  logic [AW-1:0]   in_rs1,
    input  logic [AW-1:0]   in_rs2,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_use_imm,
    input  logic [IMMW-1:0] in_imm,
    input  logic            hold,
    output logic [FW-1:0]   funct,
    output logic [DW-1:0]   data1,
    output logic [DW-1:0]   data2,
    input  logic [DW-1:0]   alu_out,
    input  logic            zero,
    output logic            ex_valid,
    output logic [AW-1:0]   ex_rd,
    output logic            zero_flag,
    output logic [CNTW-1:0] retired,
    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    idex_t           r_ex;
    idex_t           w_ex_next;
    logic            r_zero_flag;
    logic [CNTW-1:0] r_retired;

    logic            w_accept;
    logic            w_wb_en;
    logic [DW-1:0]   w_rf_rd1;
    logic [DW-1:0]   w_rf_rd2;
    logic [DW-1:0]   w_op1;
    logic [DW-1:0]   w_op2;

    reg_file_2r1w u_rf (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_wb_en),
        .i_waddr    (r_ex.rd),
        .i_wdata    (alu_out),
        .i_raddr1   (in_rs1),
        .o_rdata1   (w_rf_rd1),
        .i_raddr2   (in_rs2),
        .o_rdata2   (w_rf_rd2),
        .i_dbg_addr (dbg_addr),
        .o_dbg_data (dbg_data)
    );

    assign in_ready = ~hold;
    assign w_accept = in_valid & ~hold;
    assign w_wb_en  = r_ex.valid & (r_ex.rd != '0);

    // Operand select: r0 is zero, then the in-flight EX result, then the file.
    always_comb begin
        w_op1 = w_rf_rd1;
        if (in_rs1 == '0) begin
            w_op1 = '0;
        end else if (r_ex.valid && (r_ex.rd == in_rs1)) begin
            w_op1 = alu_out;
        end

        w_op2 = w_rf_rd2;
        if (in_use_imm) begin
            w_op2 = sign_extend(in_imm);
        end else if (in_rs2 == '0) begin
            w_op2 = '0;
        end else if (r_ex.valid && (r_ex.rd == in_rs2)) begin
            w_op2 = alu_out;
        end
    end

    // Next ID/EX content: the accepted instruction or an all-zero bubble.
    always_comb begin
        w_ex_next = '0;
        if (w_accept) begin
            w_ex_next.valid = 1'b1;
            w_ex_next.funct = in_funct;
            w_ex_next.rd    = in_rd;
            w_ex_next.data1 = w_op1;
            w_ex_next.data2 = w_op2;
        end
    end

    // ID/EX register and retire bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex        <= '0;
            r_zero_flag <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_ex <= w_ex_next;
            if (r_ex.valid) begin
                r_zero_flag <= zero;
                r_retired   <= r_retired + CNTW'(1);
            end
        end
    end

    assign funct     = r_ex.funct;
    assign data1     = r_ex.data1;
    assign data2     = r_ex.data2;
    assign ex_valid  = r_ex.valid;
    assign ex_rd     = r_ex.rd;
    assign zero_flag = r_zero_flag;
    assign retired   = r_retired;

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand/issue stage directly upstream of the ALU. Accepts one decoded instruction per cycle over a valid/ready handshake and holds the 32x32 general register file.
- Registers funct, data1 and data2 into an ID/EX pipeline register that drives the ALU. Forwards the ALU's combinational result to the next instruction.
- Writes the ALU result back into the register file at the end of the EX cycle, and keeps a latched zero flag and a retired-instruction counter.

Parameters:
- NREG, 32, number of architectural registers; r0 reads as zero.
- AW, 5, register address width, equal to log2(NREG).
- DW, 32, datapath width; must match the ALU.
- IMMW, 16, immediate width; sign-extended to DW.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle; equals ~hold.
- in_funct  in  3  ALU op: 000 CERO, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOT, 110 XOR.
- in_rs1  in  AW  source register for data1.
- in_rs2  in  AW  source register for data2.
- in_rd  in  AW  destination register.
- in_use_imm  in  1  data2 comes from the immediate instead of rs2.
- in_imm  in  IMMW  immediate value.
- hold  in  1  downstream stall; forces a bubble into EX.
- funct  out  3  to ALU.
- data1  out  DW  to ALU.
- data2  out  DW  to ALU.
- alu_out  in  DW  from ALU; combinational function of funct, data1 and data2.
- zero  in  1  from ALU.
- ex_valid  out  1  the ID/EX register holds a real instruction.
- ex_rd  out  AW  destination register of the EX instruction.
- zero_flag  out  1  zero output of the last retired instruction.
- retired  out  32  count of retired instructions.
- dbg_addr  in  AW  debug read address.
- dbg_data  out  DW  register file contents at dbg_addr; combinational; does not show a write pending this cycle.

Behaviour:
- Reset (asynchronous, active-high): all registers r0..r31 clear to 0. The following outputs go to 0: ex_valid, ex_rd, funct (000, CERO), data1, data2, zero_flag, retired. Deasserting rst clears nothing further.
- Accept: an instruction is accepted when in_valid && in_ready. On that rising edge the ID/EX register loads:
  - funct <= in_funct
  - ex_rd <= in_rd
  - ex_valid <= 1
  - data1 <= operand(in_rs1)
  - data2 <= in_use_imm ? sign_extend(in_imm) : operand(in_rs2)
- Bubble: if nothing is accepted (in_valid=0 or hold=1), the ID/EX register loads ex_valid=0, funct=000, data1=0, data2=0, ex_rd=0.
- Operand select, operand(r):
  - r==0 gives 0.
  - Otherwise, if ex_valid && ex_rd==r, the value is alu_out (forwarded).
  - Otherwise, the value is regfile[r].
  - Forwarding has priority over the register file.
- Latency: the ALU result for an instruction accepted at edge N appears on alu_out during cycle N+1. It is written back at edge N+1. Back-to-back dependent instructions need no stall.
- Write-back: at each edge with ex_valid=1 and ex_rd!=0, regfile[ex_rd] <= alu_out. Writes to r0 are dropped, but the instruction still retires.
- Retire: at each edge with ex_valid=1:
  - zero_flag <= zero
  - retired <= retired+1, wrapping from 0xFFFFFFFF to 0 with no saturation.
  - When ex_valid=0, zero_flag and retired hold.
- Hold: in_ready=0 for the cycle. The current EX instruction still writes back and retires. The next EX content is a bubble. The upstream instruction must be held stable by the producer.
- NOT (101) uses data1 only, but data2 is still loaded per the normal rule.
- CERO (000) is a real instruction: result 0, so it writes 0 to rd and sets zero_flag=1.
- Undefined funct 111 behaves as CERO at the ALU. This stage passes it through unchanged.
- Reset mid-operation discards the in-flight EX instruction without write-back.

Decomposition:
- Shared package alu_pkg holds:
  - funct encodings (CERO..XOR)
  - DW, AW, NREG defaults
  - sign-extension function
- One natural sub-module: reg_file_2r1w, containing 2 combinational read ports, 1 synchronous write port, r0 hardwired to 0, asynchronous reset, and the dbg read port as a third read port. Forwarding and the ID/EX register stay in alu_operand_stage.

Test Plan:
- Reset then dbg_addr sweep 0..31 -> dbg_data=0 for all; ex_valid=0, retired=0, zero_flag=0.
- Issue ADD rd=1, rs1=0, imm=5 (use_imm), then ADD rd=2, rs1=1, imm=-3 back-to-back -> second cycle data1=5 (forwarded), data2=0xFFFFFFFD; afterwards r1=5, r2=2, retired=2.
- SUB rd=3, rs1=2, rs2=2 -> alu_out=0, zero_flag=1 next edge, r3=0; then XOR rd=4, rs1=1, rs2=2 -> r4=7, zero_flag=0.
- Write rd=0 with ADD imm=9, then read rs1=0 -> data1=0; dbg r0=0; retired still increments.
- Assert hold for 2 cycles with in_valid=1 -> in_ready=0, ex_valid=0 both cycles, prior instruction still written back; instruction accepted on the first edge after hold drops.
- Preload retired near wrap (issue 2^32-1 instructions or force) then retire one more -> retired=0. Assert rst mid-EX of ADD rd=5 -> r5 remains 0.
